// File: rtl/f2s_pkg.sv
// Shared types, float field widths and component-order helpers for tri_float_to_screen.
package f2s_pkg;

  localparam int unsigned FLT_EXP_BIAS = 127;
  localparam int unsigned FLT_MANT_W   = 23;
  localparam int unsigned FLT_EXP_W    = 8;
  localparam int unsigned N_COMP       = 9;
  localparam int unsigned IDX_W        = 4;

  typedef logic [31:0] float32_t;

  typedef enum logic [1:0] {IDLE, CONV, DRAIN, EMIT} f2s_state_t;

  // Component order is v0.x, v0.y, v0.z, v1.x ... v2.z; comp index 2=x, 1=y, 0=z.
  function automatic logic [1:0] idx_vtx(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: idx_vtx = 2'd0;
      4'd3, 4'd4, 4'd5: idx_vtx = 2'd1;
      default:          idx_vtx = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] idx_cmp(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: idx_cmp = 2'd2;
      4'd1, 4'd4, 4'd7: idx_cmp = 2'd1;
      default:          idx_cmp = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/tri_float_to_screen_if.sv
// Triangle-in / converted-vertices-out bus between tri_proj and the rasterizer.
interface tri_float_to_screen_if #(
  parameter int unsigned OUT_W = 9
) ();

  f2s_pkg::float32_t [2:0][2:0] tri_in;
  logic                         valid_in;
  logic                         ready_out;
  logic                         obj_done_in;
  logic [2:0][OUT_W-1:0]        vert1;
  logic [2:0][OUT_W-1:0]        vert2;
  logic [2:0][OUT_W-1:0]        vert3;
  logic                         valid_tri_out;
  logic                         obj_done_out;

  modport slave (
    input  tri_in, valid_in, obj_done_in,
    output ready_out, vert1, vert2, vert3, valid_tri_out, obj_done_out
  );

  modport master (
    output tri_in, valid_in, obj_done_in,
    input  ready_out, vert1, vert2, vert3, valid_tri_out, obj_done_out
  );

endinterface

// File: rtl/float_to_uint.sv
// Single-stage registered IEEE-754 single -> unsigned OUT_W-bit saturating converter.
// F2S_ROUND_EN selects round-half-up on magnitude; otherwise truncation toward zero.
module float_to_uint
  import f2s_pkg::*;
#(
  parameter int unsigned OUT_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  float32_t         flt_i,
  output logic [OUT_W-1:0] res_o
);

  localparam int unsigned MANT_W = FLT_MANT_W + 1;
  localparam logic [OUT_W-1:0] RES_MAX = '1;

  logic                  sign_c;
  logic [FLT_EXP_W-1:0]  exp_c;
  logic [FLT_EXP_W-1:0]  exp_unb_c;
  logic [FLT_MANT_W-1:0] frac_c;
  logic [MANT_W-1:0]     mant_c;
  logic [4:0]            sh_c;
  logic [MANT_W:0]       mag_c;
  logic                  rbit_c;
  logic [OUT_W-1:0]      res_d;
  logic [OUT_W-1:0]      res_q;
`ifdef F2S_ROUND_EN
  logic [MANT_W-1:0]     rnd_c;
`endif

  always_comb begin
    sign_c    = flt_i[31];
    exp_c     = flt_i[30:FLT_MANT_W];
    frac_c    = flt_i[FLT_MANT_W-1:0];
    mant_c    = {1'b1, frac_c};
    exp_unb_c = exp_c - FLT_EXP_W'(FLT_EXP_BIAS);
    sh_c      = 5'(FLT_EXP_W'(FLT_MANT_W) - exp_unb_c);
    mag_c     = (MANT_W+1)'(mant_c >> sh_c);
`ifdef F2S_ROUND_EN
    // Bit just below the binary point; sh_c==0 wraps the shift and yields 0.
    rnd_c     = mant_c >> 5'(sh_c - 5'd1);
    rbit_c    = rnd_c[0];
`else
    rbit_c    = 1'b0;
`endif
    res_d     = '0;
    if (exp_c == '1) begin
      res_d = (frac_c == '0 && !sign_c) ? RES_MAX : '0;
    end else if (sign_c) begin
      res_d = '0;
    end else if (exp_c < FLT_EXP_W'(FLT_EXP_BIAS)) begin
`ifdef F2S_ROUND_EN
      res_d = (exp_c == FLT_EXP_W'(FLT_EXP_BIAS - 1)) ? OUT_W'(1) : '0;
`else
      res_d = '0;
`endif
    end else if (exp_unb_c >= FLT_EXP_W'(OUT_W)) begin
      res_d = RES_MAX;
    end else begin
      mag_c = mag_c + (MANT_W+1)'(rbit_c);
      res_d = (mag_c > (MANT_W+1)'(RES_MAX)) ? RES_MAX : OUT_W'(mag_c);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) res_q <= '0;
    else         res_q <= res_d;
  end

  assign res_o = res_q;

endmodule

// File: rtl/tri_float_to_screen.sv
// Converts one projected float triangle into OUT_W-bit screen vertices over 12 cycles,
// keeping obj_done ordered behind in-flight triangles. Rounding via F2S_ROUND_EN.
module tri_float_to_screen
  import f2s_pkg::*;
#(
  parameter int unsigned OUT_W = 9
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  tri_float_to_screen_if.slave  bus
);

  f2s_state_t                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [IDX_W-1:0]          res_idx_q, res_idx_d;
  logic                      res_vld_q, res_vld_d;
  float32_t [2:0][2:0]       tri_q, tri_d;
  logic [2:0][2:0][OUT_W-1:0] stage_q, stage_d;
  logic [2:0][2:0][OUT_W-1:0] vert_q, vert_d;
  logic                      ready_q, ready_d;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic                      pend_q, pend_d;
  float32_t                  conv_flt;
  logic [OUT_W-1:0]          conv_res;
  logic                      accept;

  float_to_uint #(.OUT_W(OUT_W)) u_conv (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .flt_i  (conv_flt),
    .res_o  (conv_res)
  );

  assign accept = bus.valid_in && ready_q;

  // Next-state, staging and output decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    res_idx_d = idx_q;
    res_vld_d = 1'b0;
    tri_d     = tri_q;
    stage_d   = stage_q;
    vert_d    = vert_q;
    done_d    = 1'b0;
    pend_d    = pend_q;
    conv_flt  = tri_q[idx_vtx(idx_q)][idx_cmp(idx_q)];

    // Converter result lags its input by one cycle.
    if (res_vld_q) stage_d[idx_vtx(res_idx_q)][idx_cmp(res_idx_q)] = conv_res;

    case (state_q)
      IDLE: begin
        if (accept) begin
          tri_d   = bus.tri_in;
          idx_d   = '0;
          pend_d  = bus.obj_done_in;
          state_d = CONV;
        end else begin
          done_d  = bus.obj_done_in;
        end
      end
      CONV: begin
        res_vld_d = 1'b1;
        pend_d    = pend_q || bus.obj_done_in;
        if (idx_q == IDX_W'(N_COMP - 1)) state_d = DRAIN;
        else                             idx_d   = IDX_W'(idx_q + 4'd1);
      end
      DRAIN: begin
        vert_d  = stage_d;
        pend_d  = pend_q || bus.obj_done_in;
        state_d = EMIT;
      end
      EMIT: begin
        done_d  = pend_q || bus.obj_done_in;
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    valid_d = (state_d == EMIT);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      res_idx_q <= '0;
      res_vld_q <= 1'b0;
      tri_q     <= '0;
      stage_q   <= '0;
      vert_q    <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      res_idx_q <= res_idx_d;
      res_vld_q <= res_vld_d;
      tri_q     <= tri_d;
      stage_q   <= stage_d;
      vert_q    <= vert_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      pend_q    <= pend_d;
    end
  end

  assign bus.ready_out     = ready_q;
  assign bus.valid_tri_out = valid_q;
  assign bus.obj_done_out  = done_q;
  assign bus.vert1         = vert_q[0];
  assign bus.vert2         = vert_q[1];
  assign bus.vert3         = vert_q[2];

endmodule

// File: tb/tb_tri_float_to_screen.sv
// Directed bench for tri_float_to_screen: conversion, specials, throughput, obj_done, reset.
module tb_tri_float_to_screen;
  import f2s_pkg::*;

  localparam int unsigned OUT_W = 9;

  typedef logic [2:0][31:0]            fvtx_t;
  typedef logic [2:0][2:0][31:0]       ftri_t;
  typedef logic [2:0][OUT_W-1:0]       uvtx_t;
  typedef logic [2:0][2:0][OUT_W-1:0]  uset_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  int          vt_q[$];
  int          od_q[$];
  uset_t       cap_q[$];
  logic [63:0] rdy_hist;
  int          acc_cnt;
  uset_t       last_vert;
  ftri_t       tri_a, tri_b;
  uset_t       exp_a, exp_b;

  tri_float_to_screen_if #(.OUT_W(OUT_W)) bus ();

  tri_float_to_screen #(.OUT_W(OUT_W)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_set(input string tag, input uset_t got, input uset_t exp);
    for (int v = 0; v < 3; v++)
      chk($sformatf("%s.vert%0d", tag, v + 1), 32'(got[v]), 32'(exp[v]));
  endtask

  function automatic fvtx_t fv(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {x, y, z};
  endfunction

  function automatic uvtx_t uv(input int x, input int y, input int z);
    return {OUT_W'(x), OUT_W'(y), OUT_W'(z)};
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic uset_t cur_vert();
    return {bus.vert3, bus.vert2, bus.vert1};
  endfunction

  // Caller has driven cycle-0 inputs; steps cycles 1..ncyc and logs outputs.
  task automatic observe(input int ncyc, input int hold_last, input int od_at, input ftri_t tri_next);
    vt_q.delete(); od_q.delete(); cap_q.delete();
    rdy_hist = '0;
    acc_cnt  = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      bus.tri_in      = tri_next;
      bus.valid_in    = (c <= hold_last);
      bus.obj_done_in = (c == od_at);
      rdy_hist[c]     = bus.ready_out;
      if (bus.valid_in && bus.ready_out) acc_cnt++;
      if (bus.valid_tri_out) begin
        vt_q.push_back(c);
        cap_q.push_back(cur_vert());
      end
      if (bus.obj_done_out) od_q.push_back(c);
    end
    last_vert       = cur_vert();
    bus.valid_in    = 1'b0;
    bus.obj_done_in = 1'b0;
  endtask

  task automatic start(input ftri_t t, input logic od);
    bus.tri_in      = t;
    bus.valid_in    = 1'b1;
    bus.obj_done_in = od;
  endtask

  initial begin
    tri_a[0] = fv(32'h41A00000, 32'h41A00000, 32'h41F00000);
    tri_a[1] = fv(32'h41A00000, 32'h42200000, 32'h41F00000);
    tri_a[2] = fv(32'h42200000, 32'h41A00000, 32'h41F00000);
    exp_a    = {uv(40, 20, 30), uv(20, 40, 30), uv(20, 20, 30)};

    // 30.75, -5.0, 1000.0 / NaN, +inf, 0.5 / -0.0, 511.5, 1.0
    tri_b[0] = fv(32'h41F60000, 32'hC0A00000, 32'h447A0000);
    tri_b[1] = fv(32'h7FC00000, 32'h7F800000, 32'h3F000000);
    tri_b[2] = fv(32'h80000000, 32'h43FFC000, 32'h3F800000);
`ifdef F2S_ROUND_EN
    exp_b    = {uv(0, 511, 1), uv(0, 511, 1), uv(31, 0, 511)};
`else
    exp_b    = {uv(0, 511, 1), uv(0, 511, 0), uv(30, 0, 511)};
`endif

    bus.tri_in      = '0;
    bus.valid_in    = 1'b0;
    bus.obj_done_in = 1'b0;
    rst_n           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 32'(bus.ready_out), 32'd1);
    chk("rst.valid", 32'(bus.valid_tri_out), 32'd0);
    chk("rst.done", 32'(bus.obj_done_out), 32'd0);
    chk_set("rst", cur_vert(), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single triangle: pulse at 11, ready back at 12, vertices held afterwards.
    start(tri_a, 1'b0);
    observe(14, 0, 0, tri_a);
    chk("t1.vt_cnt", 32'(vt_q.size()), 32'd1);
    chk("t1.vt_cyc", 32'(qat(vt_q, 0)), 32'd11);
    chk("t1.od_cnt", 32'(od_q.size()), 32'd0);
    chk("t1.rdy_low", 32'(rdy_hist[11:1]), 32'd0);
    chk("t1.rdy_12", 32'(rdy_hist[12]), 32'd1);
    if (cap_q.size() > 0) chk_set("t1.cap", cap_q[0], exp_a);
    else chk("t1.cap_present", 32'd0, 32'd1);
    chk_set("t1.hold", last_vert, exp_a);

    // Back-to-back: valid held until the second handshake; B carries the special values.
    start(tri_a, 1'b0);
    observe(30, 23, 0, tri_b);
    chk("t2.accepts", 32'(acc_cnt + 1), 32'd2);
    chk("t2.vt_cnt", 32'(vt_q.size()), 32'd2);
    chk("t2.vt_cyc0", 32'(qat(vt_q, 0)), 32'd11);
    chk("t2.vt_cyc1", 32'(qat(vt_q, 1)), 32'd23);
    chk("t2.rdy_low_a", 32'(rdy_hist[11:1]), 32'd0);
    chk("t2.rdy_12", 32'(rdy_hist[12]), 32'd1);
    chk("t2.rdy_low_b", 32'(rdy_hist[23:13]), 32'd0);
    chk("t2.rdy_24", 32'(rdy_hist[24]), 32'd1);
    if (cap_q.size() > 1) begin
      chk_set("t2.capA", cap_q[0], exp_a);
      chk_set("t2.capB", cap_q[1], exp_b);
    end else chk("t2.cap_present", 32'(cap_q.size()), 32'd2);

    // obj_done with the handshake plus another mid-conversion: one pulse after EMIT.
    start(tri_a, 1'b1);
    observe(16, 0, 5, tri_a);
    chk("t3.vt_cnt", 32'(vt_q.size()), 32'd1);
    chk("t3.vt_cyc", 32'(qat(vt_q, 0)), 32'd11);
    chk("t3.od_cnt", 32'(od_q.size()), 32'd1);
    chk("t3.od_cyc", 32'(qat(od_q, 0)), 32'd12);

    // obj_done alone in IDLE.
    bus.obj_done_in = 1'b1;
    observe(4, 0, 0, tri_a);
    chk("t4.od_cnt", 32'(od_q.size()), 32'd1);
    chk("t4.od_cyc", 32'(qat(od_q, 0)), 32'd1);
    chk("t4.vt_cnt", 32'(vt_q.size()), 32'd0);

    // Reset at cycle 6 of a conversion with obj_done pending.
    start(tri_b, 1'b1);
    observe(5, 0, 0, tri_b);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5.rst_valid", 32'(bus.valid_tri_out), 32'd0);
    chk("t5.rst_done", 32'(bus.obj_done_out), 32'd0);
    chk("t5.rst_ready", 32'(bus.ready_out), 32'd1);
    chk_set("t5.rst", cur_vert(), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    observe(20, 0, 0, tri_b);
    chk("t5.vt_cnt", 32'(vt_q.size()), 32'd0);
    chk("t5.od_cnt", 32'(od_q.size()), 32'd0);
    chk("t5.rdy_high", 32'(rdy_hist[20:1]), 32'hFFFFF);
    chk_set("t5.after", last_vert, '0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
